param_delay_line: RTL

Parametrised successor to the single-bit flip-flop stage. It is a WIDTH-bit, DEPTH-stage register delay line with clock enable, synchronous flush, a valid bit carried per stage, a selectable tap output and an occupancy counter. Every stage updates with non-blocking semantics, so data advances exactly one stage per enabled clock and never falls through multiple stages in one cycle. It sits between datapath blocks that need a fixed, programmable-observation delay.

---
 rtl/param_delay_line.sv | 69 ++++++
 1 files changed

// File: rtl/param_delay_line.sv
// param_delay_line: WIDTH x DEPTH delay line with per-stage valid, clock enable,
// synchronous flush, selectable tap and occupancy count.
module param_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int TW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d,
  input  logic [TW-1:0]    tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [WIDTH-1:0] tap_q,
  output logic             tap_valid,
  output logic [CW-1:0]    fill_cnt,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  always_comb begin
    stage_d[0] = d;
    vld_d[0] = in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
      vld_d[i] = vld_q[i-1];
    end
    // one sample enters and one leaves per enabled edge
    cnt_d = cnt_q + CW'(in_valid) - CW'(vld_q[DEPTH-1]);
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      vld_q <= '0;
      cnt_q <= '0;
    end else if (en) begin
      stage_q <= stage_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end
  assign q = stage_q[DEPTH-1];
  assign q_valid = vld_q[DEPTH-1];
  assign fill_cnt = cnt_q;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  if (DEPTH == 1) begin : g_one
    assign tap_q = stage_q[0];
    assign tap_valid = vld_q[0];
  end else if ((1 << TW) == DEPTH) begin : g_pow2
    assign tap_q = stage_q[tap_sel];
    assign tap_valid = vld_q[tap_sel];
  end else begin : g_guard
    // tap_sel can name a stage that does not exist
    logic in_range;
    assign in_range = 32'(tap_sel) < DEPTH;
    assign tap_q = in_range ? stage_q[tap_sel] : '0;
    assign tap_valid = in_range ? vld_q[tap_sel] : 1'b0;
  end
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) 32'(cnt_q) <= DEPTH);
  a_cnt_pop: assert property (@(posedge clk) disable iff (rst) 32'(cnt_q) == $countones(vld_q));
endmodule
